aes_round_ops: RTL and testbench
================================

// Module: aes_round_ops
// PURPOSE
//  Registered AES-128 round-transform datapath: AddRoundKey, ShiftRows and MixColumns (FIPS-197).
//  Provides three independent units, each with its own enable/done handshake.
//  Sits under the encryption control FSM, which sequences the units per round.
//  The FSM also applies SubBytes (external, combinational) between AddRoundKey and ShiftRows.
// PARAMETERS
//  none (block width fixed at 128 bits; AES-128 only)
// PORTS
//  Clocking: one clock; reset is asynchronous and active-high.
//  clk        in   1    rising-edge clock
//  rst        in   1    reset; asynchronous, active-high
//  ark_en     in   1    AddRoundKey enable
//  ark_key    in   128  round key
//  ark_state  in   128  state input
//  ark_out    out  128  ark_state ^ ark_key, registered
//  ark_done   out  1    AddRoundKey result valid
//  sr_en      in   1    ShiftRows enable
//  sr_in      in   128  state input (already SubBytes'd)
//  sr_out     out  128  ShiftRows(sr_in), registered
//  sr_done    out  1    ShiftRows result valid
//  mc_en      in   1    MixColumns enable
//  mc_in      in   128  state input
//  mc_out     out  128  MixColumns(mc_in), registered
//  mc_done    out  1    MixColumns result valid
// BEHAVIOUR
//  Byte order: bits [127:120] = byte 0 = s(0,0). Bytes are column-major: byte 4c+r = s(r,c).
//  Reset (async, any time, including mid-operation):
//   - all *_out go to 128'h0 and all *_done go to 0 immediately.
//   - Registers stay cleared until after the first rising edge with rst low.
//  Each unit is identical in timing and independent; units may be enabled simultaneously.
//  On each rising edge with en=1:
//   - out <= f(current inputs); done <= 1.
//   - Latency is 1 cycle: done and out are valid together in the cycle after en is first sampled high.
//   - While en stays high, out re-evaluates every cycle (tracks input changes with 1-cycle delay) and done stays 1.
//  On each rising edge with en=0:
//   - done <= 0.
//   - out holds its last value; the FSM reads ark_out/sr_out after dropping en.
//  No internal state machine; the done flop is the only control state.
//  AddRoundKey: bitwise 128-bit XOR.
//  ShiftRows: row r rotated left by r bytes, i.e. out s(r,c) = in s(r,(c+r) mod 4). Row 0 unchanged.
//  MixColumns, per column [a0..a3] -> [b0..b3], arithmetic in GF(2^8), poly 0x11B:
//   - b0 = 2a0 ^ 3a1 ^ a2 ^ a3
//   - b1 = a0 ^ 2a1 ^ 3a2 ^ a3
//   - b2 = a0 ^ a1 ^ 2a2 ^ 3a3
//   - b3 = 3a0 ^ a1 ^ a2 ^ 2a3
//   - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00); 3x = xtime(x) ^ x.
//  No X propagation: all outputs are defined from reset onward.
// STRUCTURE
//  Shared package aes_pkg:
//   - function xtime(8b) and function gmul3(8b)
//   - typedef state_t (128b) and word_t (32b)
//   - localparam AES_POLY = 8'h1B
//  One sub-module: aes_mix_column (combinational, 32b column in -> 32b out), instantiated 4x.
//  ShiftRows is pure wiring; AddRoundKey is an XOR. Each unit has its own output register and done flop.
// TESTING
//  1 Reset: assert rst mid-operation with all en=1 -> all outs 0, all done 0 with no clock edge.
//  2 ARK: key=2b7e151628aed2a6abf7158809cf4f3c, state=3243f6a8885a308d313198a2e0370734, en 1 cycle
//    -> next cycle ark_out=193de3bea0f4e22b9ac68d2ae9f84808, ark_done=1.
//    -> following cycle ark_done=0 and ark_out held.
//  3 SR: sr_in=d42711aee0bf98f1b8b45de51e415230 -> sr_out=d4bf5d30e0b452aeb84111f11e2798e5.
//  4 MC: mc_in=d4bf5d30e0b452aeb84111f11e2798e5 -> mc_out=046681e5e0cb199a48f8d37a2806264c.
//    Column check: db135345 -> 8e4da1bc.
//  5 Round chain: ARK of 046681e5e0cb199a48f8d37a2806264c with key a0fafe1788542cb123a339392a6c7605
//    -> a49c7ff2689f352b6b5bea43026a5049.
//  6 Handshake: all three en held high 5 cycles with inputs changing each cycle
//    -> done stays 1; each out = f(input of previous cycle); units independent.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 types and GF(2^8) helpers for the round-transform datapath.
package aes_pkg;

   typedef logic [127:0] state_t;
   typedef logic [31:0]  word_t;

   // Low byte of the AES reduction polynomial x^8 + x^4 + x^3 + x + 1.
   localparam logic [7:0] AES_POLY = 8'h1B;

   // Multiply by x (i.e. by 2) in GF(2^8), reducing when the top bit falls out.
   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
   endfunction

   // Multiply by x+1 (i.e. by 3) in GF(2^8).
   function automatic logic [7:0] gmul3(input logic [7:0] x);
      return xtime(x) ^ x;
   endfunction

endpackage

// File: rtl/aes_mix_column.sv
// MixColumns for a single 32-bit state column; purely combinational.
// colIn[31:24] is row 0 (a0), colIn[7:0] is row 3 (a3).
module aes_mix_column
   import aes_pkg::*;
(
   input  word_t colIn,
   output word_t colOut
);

   logic [7:0] a0, a1, a2, a3;

   assign a0 = colIn[31:24];
   assign a1 = colIn[23:16];
   assign a2 = colIn[15:8];
   assign a3 = colIn[7:0];

   // Fixed circulant matrix [2 3 1 1] applied to the column.
   always_comb begin
      colOut[31:24] = xtime(a0) ^ gmul3(a1) ^ a2        ^ a3;
      colOut[23:16] = a0        ^ xtime(a1) ^ gmul3(a2) ^ a3;
      colOut[15:8]  = a0        ^ a1        ^ xtime(a2) ^ gmul3(a3);
      colOut[7:0]   = gmul3(a0) ^ a1        ^ a2        ^ xtime(a3);
   end

endmodule

// File: rtl/aes_round_ops.sv
// Registered AES-128 AddRoundKey, ShiftRows and MixColumns units.
//
// Handshake (identical for all three units, which are fully independent):
//   each rising edge with <unit>_en=1 loads <unit>_out with f(current inputs)
//   and sets <unit>_done, so results appear one cycle after en is sampled high
//   and keep tracking the inputs (one cycle behind) for as long as en stays
//   high. An edge with en=0 clears done but leaves out untouched, so the
//   sequencer may read the result after dropping en. Reset clears everything
//   asynchronously. There is no FSM; the done flop is the only control state.
//
// Byte k of a state occupies bits [127-8k -: 8]; byte 4c+r is s(r,c).
module aes_round_ops
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         ark_en,
   input  logic [127:0] ark_key,
   input  logic [127:0] ark_state,
   output logic [127:0] ark_out,
   output logic         ark_done,
   input  logic         sr_en,
   input  logic [127:0] sr_in,
   output logic [127:0] sr_out,
   output logic         sr_done,
   input  logic         mc_en,
   input  logic [127:0] mc_in,
   output logic [127:0] mc_out,
   output logic         mc_done
);

   state_t srComb;
   state_t mcComb;

   // ShiftRows is pure wiring: out s(r,c) = in s(r,(c+r) mod 4).
   for (genvar c = 0; c < 4; c++) begin : g_srCol
      for (genvar r = 0; r < 4; r++) begin : g_srRow
         assign srComb[127-8*(4*c+r) -: 8] = sr_in[127-8*(4*((c+r)%4)+r) -: 8];
      end
   end

   // One MixColumns instance per state column.
   for (genvar c = 0; c < 4; c++) begin : g_mcCol
      aes_mix_column uMixColumn (
         .colIn  (mc_in[127-32*c -: 32]),
         .colOut (mcComb[127-32*c -: 32])
      );
   end

   // AddRoundKey result register and done flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ark_out  <= '0;
         ark_done <= 1'b0;
      end else begin
         ark_done <= ark_en;
         if (ark_en) ark_out <= ark_state ^ ark_key;
      end
   end

   // ShiftRows result register and done flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_out  <= '0;
         sr_done <= 1'b0;
      end else begin
         sr_done <= sr_en;
         if (sr_en) sr_out <= srComb;
      end
   end

   // MixColumns result register and done flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mc_out  <= '0;
         mc_done <= 1'b0;
      end else begin
         mc_done <= mc_en;
         if (mc_en) mc_out <= mcComb;
      end
   end

endmodule

// File: tb/tb_aes_round_ops.sv
// Directed, table-driven bench for aes_round_ops with hand-computed vectors.
module tb_aes_round_ops;

   localparam int U_ARK = 0;
   localparam int U_SR  = 1;
   localparam int U_MC  = 2;
   localparam int NVEC  = 8;

   typedef struct {
      int           unit;
      logic [127:0] a;     // ark_state / sr_in / mc_in
      logic [127:0] b;     // ark_key (ARK only)
      logic [127:0] exp;
   } vec_t;

   logic         clk;
   logic         rst;
   logic         ark_en, sr_en, mc_en;
   logic [127:0] ark_key, ark_state, sr_in, mc_in;
   logic [127:0] ark_out, sr_out, mc_out;
   logic         ark_done, sr_done, mc_done;

   vec_t         vec [NVEC];
   logic [127:0] exp_q [$];
   logic [127:0] ark_q [$];
   logic [127:0] sr_q [$];
   logic [127:0] mc_q [$];
   int           check_count;
   int           pass_count;

   aes_round_ops dut (
      .clk       (clk),
      .rst       (rst),
      .ark_en    (ark_en),
      .ark_key   (ark_key),
      .ark_state (ark_state),
      .ark_out   (ark_out),
      .ark_done  (ark_done),
      .sr_en     (sr_en),
      .sr_in     (sr_in),
      .sr_out    (sr_out),
      .sr_done   (sr_done),
      .mc_en     (mc_en),
      .mc_in     (mc_in),
      .mc_out    (mc_out),
      .mc_done   (mc_done)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance past the next rising edge; inputs are driven and outputs sampled here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      check_count++;
      if (act === exp) pass_count++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [127:0] unit_out(input int u);
      case (u)
         U_ARK:   return ark_out;
         U_SR:    return sr_out;
         default: return mc_out;
      endcase
   endfunction

   function automatic logic unit_done(input int u);
      case (u)
         U_ARK:   return ark_done;
         U_SR:    return sr_done;
         default: return mc_done;
      endcase
   endfunction

   function automatic string unit_name(input int u);
      case (u)
         U_ARK:   return "ark";
         U_SR:    return "sr";
         default: return "mc";
      endcase
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // ---------------- drivers ----------------
   task automatic drive_unit(input int u, input logic en, input logic [127:0] a, input logic [127:0] b);
      case (u)
         U_ARK: begin ark_en = en; ark_state = a; ark_key = b; end
         U_SR:  begin sr_en = en; sr_in = a; end
         default: begin mc_en = en; mc_in = a; end
      endcase
   endtask

   task automatic drive_vec(input int idx, input logic en);
      drive_unit(vec[idx].unit, en, vec[idx].a, vec[idx].b);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " ark_out"}, ark_out, 128'h0);
      check({tag, " sr_out"}, sr_out, 128'h0);
      check({tag, " mc_out"}, mc_out, 128'h0);
      check({tag, " ark_done"}, {127'h0, ark_done}, 128'h0);
      check({tag, " sr_done"}, {127'h0, sr_done}, 128'h0);
      check({tag, " mc_done"}, {127'h0, mc_done}, 128'h0);
   endtask

   // ---------------- test ----------------
   int ark_idx [5] = '{0, 1, 2, 0, 1};
   int sr_idx  [5] = '{3, 4, 3, 4, 3};
   int mc_idx  [5] = '{5, 6, 7, 5, 6};

   initial begin
      logic [127:0] held;
      check_count = 0;
      pass_count  = 0;

      // Hand-computed vectors (FIPS-197 worked examples and known MixColumns columns).
      vec[0] = '{U_ARK, 128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                 128'h193de3bea0f4e22b9ac68d2ae9f84808};
      vec[1] = '{U_ARK, 128'h046681e5e0cb199a48f8d37a2806264c, 128'ha0fafe1788542cb123a339392a6c7605,
                 128'ha49c7ff2689f352b6b5bea43026a5049};
      vec[2] = '{U_ARK, 128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                 128'h00102030405060708090a0b0c0d0e0f0};
      vec[3] = '{U_SR, 128'hd42711aee0bf98f1b8b45de51e415230, 128'h0,
                 128'hd4bf5d30e0b452aeb84111f11e2798e5};
      vec[4] = '{U_SR, 128'h000102030405060708090a0b0c0d0e0f, 128'h0,
                 128'h00050a0f04090e03080d02070c01060b};
      vec[5] = '{U_MC, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 128'h0,
                 128'h046681e5e0cb199a48f8d37a2806264c};
      vec[6] = '{U_MC, 128'hdb135345f20a225c01010101c6c6c6c6, 128'h0,
                 128'h8e4da1bc9fdc589d01010101c6c6c6c6};
      vec[7] = '{U_MC, 128'h2d26314c2d26314c2d26314c2d26314c, 128'h0,
                 128'h4d7ebdf84d7ebdf84d7ebdf84d7ebdf8};

      rst = 1'b1;
      ark_en = 1'b0; sr_en = 1'b0; mc_en = 1'b0;
      ark_key = '0; ark_state = '0; sr_in = '0; mc_in = '0;
      tick();
      tick();
      check_all_zero("reset");

      // Release reset with all enables high, run two cycles, then reset mid-cycle.
      rst = 1'b0;
      drive_vec(0, 1'b1);
      drive_vec(3, 1'b1);
      drive_vec(5, 1'b1);
      tick();
      tick();
      check("pre-reset ark_out", ark_out, vec[0].exp);
      check("pre-reset mc_done", {127'h0, mc_done}, 128'h1);
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("async reset");
      tick();
      ark_en = 1'b0; sr_en = 1'b0; mc_en = 1'b0;
      rst = 1'b0;
      check_all_zero("reset release");
      tick();
      check_all_zero("after release");

      // Table loop: one-cycle enable, result next cycle, then done drops with out held.
      for (int i = 0; i < NVEC; i++) begin
         int u;
         u = vec[i].unit;
         drive_vec(i, 1'b1);
         exp_q.push_back(vec[i].exp);
         tick();
         drive_unit(u, 1'b0, rand128(), rand128());
         held = exp_q.pop_front();
         check($sformatf("vec%0d %s out", i, unit_name(u)), unit_out(u), held);
         check($sformatf("vec%0d %s done", i, unit_name(u)), {127'h0, unit_done(u)}, 128'h1);
         tick();
         check($sformatf("vec%0d %s done drop", i, unit_name(u)), {127'h0, unit_done(u)}, 128'h0);
         check($sformatf("vec%0d %s hold", i, unit_name(u)), unit_out(u), held);
      end

      // All three units streaming with inputs changing every cycle.
      drive_vec(ark_idx[0], 1'b1);
      drive_vec(sr_idx[0], 1'b1);
      drive_vec(mc_idx[0], 1'b1);
      ark_q.push_back(vec[ark_idx[0]].exp);
      sr_q.push_back(vec[sr_idx[0]].exp);
      mc_q.push_back(vec[mc_idx[0]].exp);
      for (int i = 1; i <= 5; i++) begin
         tick();
         check($sformatf("stream%0d ark_out", i), ark_out, ark_q.pop_front());
         check($sformatf("stream%0d sr_out", i), sr_out, sr_q.pop_front());
         check($sformatf("stream%0d mc_out", i), mc_out, mc_q.pop_front());
         check($sformatf("stream%0d dones", i), {125'h0, ark_done, sr_done, mc_done}, 128'h7);
         if (i < 5) begin
            drive_vec(ark_idx[i], 1'b1);
            drive_vec(sr_idx[i], 1'b1);
            drive_vec(mc_idx[i], 1'b1);
            ark_q.push_back(vec[ark_idx[i]].exp);
            sr_q.push_back(vec[sr_idx[i]].exp);
            mc_q.push_back(vec[mc_idx[i]].exp);
         end
      end

      // Drop only MixColumns: the other two keep running on unchanged inputs.
      mc_en = 1'b0;
      mc_in = rand128();
      tick();
      check("indep mc_done", {127'h0, mc_done}, 128'h0);
      check("indep mc_out held", mc_out, vec[mc_idx[4]].exp);
      check("indep ark_done", {127'h0, ark_done}, 128'h1);
      check("indep ark_out", ark_out, vec[ark_idx[4]].exp);
      check("indep sr_out", sr_out, vec[sr_idx[4]].exp);

      ark_en = 1'b0; sr_en = 1'b0;
      tick();
      check("final dones", {125'h0, ark_done, sr_done, mc_done}, 128'h0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
